// File: rtl/sync_sp_ram.sv
// ---------------------------------------------------------------------------
// sync_sp_ram - synchronous single-port RAM with byte enables, registered
// read data and a hardware clear engine.
//
// After reset (or a clear_in pulse while idle) the clear engine walks every
// word and writes zero, one word per cycle. Accesses are accepted only in
// IDLE.
//
// Optional build macro:
//   SPRAM_OUTREG_EN - adds one extra register stage on rdata_out/rvalid_out
//                     (read latency 2 instead of 1).
//
// Ports:
//   clk_in      clock, rising edge
//   rst_in      synchronous active-high reset
//   req_in      access request, accepted when req_in && ready_out
//   we_in       1 = write, 0 = read
//   addr_in     word address
//   be_in       per-byte write enables
//   wdata_in    write data
//   clear_in    pulse: start a full clear (ignored while clearing)
//   ready_out   accesses accepted (IDLE)
//   busy_out    clear engine running
//   rvalid_out  one-cycle read strobe
//   rdata_out   read data, holds the last read value
// ---------------------------------------------------------------------------

// One byte lane: storage plus its slice of the registered read port.
module sync_sp_ram_lane #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [7:0]            o_rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Storage is not reset; the clear engine zeroes it after reset.
    always_ff @(posedge clk_in) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)    r_rdata <= 8'h00;
        else if (i_re) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

module sync_sp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_in,
    input  logic                    we_in,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [DATA_WIDTH/8-1:0] be_in,
    input  logic [DATA_WIDTH-1:0]   wdata_in,
    input  logic                    clear_in,
    output logic                    ready_out,
    output logic                    busy_out,
    output logic                    rvalid_out,
    output logic [DATA_WIDTH-1:0]   rdata_out
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (clear_in) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    logic w_idle, w_acc, w_rd, w_wr, w_clr_wr;

    assign w_idle    = (r_state == ST_IDLE);
    assign ready_out = w_idle;
    assign busy_out  = ~w_idle;

    // Nothing touches the array on a reset edge; the clear restarts cleanly.
    assign w_acc    = req_in & w_idle & ~rst_in;
    assign w_rd     = w_acc & ~we_in;
    assign w_wr     = w_acc & we_in;
    assign w_clr_wr = ~w_idle & ~rst_in;

    logic [ADDR_WIDTH-1:0]      w_lane_addr;
    logic [NUM_LANES-1:0][7:0]  w_lane_rdata;

    assign w_lane_addr = w_clr_wr ? r_cnt : addr_in;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            sync_sp_ram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
                .clk_in  (clk_in),
                .rst_in  (rst_in),
                .i_we    (w_clr_wr | (w_wr & be_in[g])),
                .i_re    (w_rd),
                .i_addr  (w_lane_addr),
                .i_wdata (w_clr_wr ? 8'h00 : wdata_in[g*8 +: 8]),
                .o_rdata (w_lane_rdata[g])
            );
        end
    endgenerate

`ifdef SPRAM_OUTREG_EN
    // Extra output stage; it keeps shifting while the clear runs so an
    // in-flight read still completes.
    logic [2:1]            r_vld_pipe;
    logic [DATA_WIDTH-1:0] r_rdata_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_vld_pipe <= '0;
            r_rdata_q  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], w_rd};
            if (r_vld_pipe[1]) r_rdata_q <= w_lane_rdata;
        end
    end

    assign rvalid_out = r_vld_pipe[2];
    assign rdata_out  = r_rdata_q;
`else
    logic [1:1] r_vld_pipe;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_vld_pipe <= '0;
        else        r_vld_pipe <= w_rd;
    end

    assign rvalid_out = r_vld_pipe[1];
    assign rdata_out  = w_lane_rdata;
`endif
endmodule

// File: tb/tb_sync_sp_ram.sv
module tb_sync_sp_ram;
    localparam int DW = 16, AW = 3, DEPTH = 8;
`ifdef SPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic rst = 1, req = 0, we = 0, clr = 0;
    logic [AW-1:0] addr = '0;
    logic [1:0] be = '0;
    logic [DW-1:0] wdata = '0;
    logic ready, busy, rvalid;
    logic [DW-1:0] rdata;

    sync_sp_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_in(clk), .rst_in(rst), .req_in(req), .we_in(we), .addr_in(addr),
        .be_in(be), .wdata_in(wdata), .clear_in(clr), .ready_out(ready),
        .busy_out(busy), .rvalid_out(rvalid), .rdata_out(rdata));

    // DUT B: 32-bit words, 64 entries
    logic b_rst = 1, b_req = 0, b_we = 0, b_clr = 0;
    logic [5:0] b_addr = '0;
    logic [3:0] b_be = '0;
    logic [31:0] b_wdata = '0;
    logic b_ready, b_busy, b_rvalid;
    logic [31:0] b_rdata;

    sync_sp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut_b (
        .clk_in(clk), .rst_in(b_rst), .req_in(b_req), .we_in(b_we), .addr_in(b_addr),
        .be_in(b_be), .wdata_in(b_wdata), .clear_in(b_clr), .ready_out(b_ready),
        .busy_out(b_busy), .rvalid_out(b_rvalid), .rdata_out(b_rdata));

    int vec = 0, miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- behavioural model of DUT A ----------------
    // Memory as a plain array; a clear is "all words zero, then DEPTH busy
    // cycles". Read results travel through a LAT-deep list of expectations.
    logic [DW-1:0] mmem [DEPTH];
    int            busy_left = 0;
    bit            m_init = 0;
    logic          ev [LAT];
    logic [DW-1:0] ed [LAT];
    logic [DW-1:0] m_rdata = '0;

    typedef struct { logic [DW-1:0] d; int cyc; } rd_t;
    rd_t rdq[$];
    int  cyc = 0;

    // Outputs are compared at the falling edge; the model is then advanced
    // with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        cyc++;
        if (rvalid === 1'b1) rdq.push_back('{d: rdata, cyc: cyc});
        if (m_init) begin
            chk("ready", ready, busy_left == 0);
            chk("busy", busy, busy_left != 0);
            chk("rvalid", rvalid, ev[LAT-1]);
            chk("rdata", rdata, m_rdata);
        end
        if (rst) begin
            m_init = 1;
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            for (int i = 0; i < LAT; i++) begin ev[i] = 0; ed[i] = '0; end
            m_rdata = '0;
        end else if (m_init) begin
            automatic bit acc = req && (busy_left == 0);
            for (int i = LAT-1; i > 0; i--) begin ev[i] = ev[i-1]; ed[i] = ed[i-1]; end
            ev[0] = acc && !we;
            ed[0] = mmem[addr];
            if (acc && we)
                for (int b = 0; b < DW/8; b++)
                    if (be[b]) mmem[addr][8*b +: 8] = wdata[8*b +: 8];
            if (busy_left > 0) busy_left--;
            else if (clr) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            end
            if (ev[LAT-1]) m_rdata = ed[LAT-1];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_q(input int n);
        int k = 0;
        while (rdq.size() < n && k < 20) begin tick(); k++; end
        if (rdq.size() < n) chk("rd_timeout", rdq.size(), n);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] b);
        req = 1; we = 1; addr = a; wdata = d; be = b;
        tick();
        req = 0; we = 0;
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_t r;
        req = 1; we = 0; addr = a;
        tick();
        req = 0;
        wait_q(1);
        if (rdq.size() > 0) begin r = rdq.pop_front(); chk(name, r.d, exp); end
    endtask

    task automatic count_busy(input string name, input int exp);
        int n = 0;
        while (!ready && n < 100) begin tick(); n++; end
        chk(name, n, exp);
    endtask

    task automatic bwr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
        b_req = 1; b_we = 1; b_addr = a; b_wdata = d; b_be = b;
        tick();
        b_req = 0; b_we = 0;
    endtask

    task automatic brd(input string name, input logic [5:0] a, input logic [31:0] exp);
        int k = 0;
        b_req = 1; b_we = 0; b_addr = a;
        tick();
        b_req = 0;
        while (!b_rvalid && k < 5) begin tick(); k++; end
        chk({name, "_vld"}, b_rvalid, 1'b1);
        chk(name, b_rdata, exp);
    endtask

    initial begin
        rd_t r0, r1;
        int n;

        // Reset release: 8 busy cycles then all zero
        tick(); tick();
        rst = 0;
        chk("busy_after_rst", busy, 1'b1);
        count_busy("clear_len_rst", 8);
        for (int i = 0; i < DEPTH; i++) rd("rd_zero_init", AW'(i), 16'h0000);

        // Byte-enabled write
        wr(3'd5, 16'hA5C3, 2'b11);
        wr(3'd5, 16'h1234, 2'b01);
        rd("rd_byte_en", 3'd5, 16'hA534);
        wr(3'd5, 16'hFFFF, 2'b00);
        rd("rd_be_zero", 3'd5, 16'hA534);

        // Back-to-back write, read, read
        wr(3'd7, 16'h7777, 2'b11);
        req = 1; we = 1; addr = 3'd2; wdata = 16'hBEEF; be = 2'b11;
        tick();
        we = 0;
        tick();
        addr = 3'd7;
        tick();
        req = 0;
        wait_q(2);
        if (rdq.size() >= 2) begin
            r0 = rdq.pop_front(); r1 = rdq.pop_front();
            chk("b2b_first", r0.d, 16'hBEEF);
            chk("b2b_second", r1.d, 16'h7777);
            chk("b2b_consecutive", r1.cyc - r0.cyc, 1);
        end

        // Clear with a read in the same cycle; writes held during clear
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hFFFF, 2'b11);
        req = 1; we = 0; addr = 3'd3; clr = 1;
        tick();
        clr = 0; we = 1; addr = 3'd0; wdata = 16'h5555; be = 2'b11;
        chk("busy_after_clr", busy, 1'b1);
        count_busy("clear_len_pulse", 8);
        req = 0; we = 0;
        wait_q(1);
        chk("clr_rd_count", rdq.size(), 1);
        if (rdq.size() > 0) begin r0 = rdq.pop_front(); chk("rd_pre_clear", r0.d, 16'hFFFF); end
        for (int i = 0; i < DEPTH; i++) rd("rd_zero_clr", AW'(i), 16'h0000);

        // Reset on the 4th clear cycle
        wr(3'd6, 16'h6666, 2'b11);
        wr(3'd1, 16'h1111, 2'b11);
        clr = 1;
        tick();
        clr = 0;
        tick(); tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        count_busy("clear_len_rst_mid", 8);
        for (int i = 0; i < DEPTH; i++) rd("rd_zero_rstclr", AW'(i), 16'h0000);
        chk("no_stray_rvalid", rdq.size(), 0);

        // 32-bit / 64-deep instance
        b_rst = 0;
        n = 0;
        while (!b_ready && n < 200) begin tick(); n++; end
        chk("b_clear_len", n, 64);
        brd("b_rd_zero", 6'd10, 32'h0);
        bwr(6'd63, 32'hFFFF_FFFF, 4'b1111);
        bwr(6'd63, 32'h1122_3344, 4'b1010);
        brd("b_rd_be1010", 6'd63, 32'h11FF_33FF);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/sync_sp_ram.md
# sync_sp_ram

Synchronous, parametrised single-port RAM replacing the tristate, level-sensitive 8x16 memory. Separate write/read data buses, request/ready handshake, per-byte write enables, registered read data with a valid strobe, and a hardware clear engine that zeroes every location after reset or on demand. Used as the general local-storage macro behind register files and small buffers.

## Interface
- DATA_WIDTH, 16: word width in bits; multiple of 8.
- ADDR_WIDTH, 3: address bits; DEPTH = 2**ADDR_WIDTH words.
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- req_in  input  1  access request; accepted on an edge where req_in && ready_out.
- we_in  input  1  1 = write, 0 = read; sampled with req_in.
- addr_in  input  ADDR_WIDTH  word address.
- be_in  input  DATA_WIDTH/8  byte enables for writes; bit i covers wdata_in[8i+7:8i].
- wdata_in  input  DATA_WIDTH  write data.
- clear_in  input  1  single-cycle pulse; starts a full clear when idle.
- ready_out  output  1  high when accesses are accepted (IDLE state).
- busy_out  output  1  high while the clear engine runs.
- rvalid_out  output  1  one-cycle strobe; rdata_out carries read result.
- rdata_out  output  DATA_WIDTH  read data; holds last read value between reads.

## Operation
- FSM states: CLEAR, IDLE.
- Reset: state <= CLEAR, clear counter <= 0, rvalid_out <= 0, rdata_out <= 0, output pipeline cleared. During and directly after reset: busy_out = 1, ready_out = 0.
- CLEAR: each cycle writes all-zero to mem[counter], counter increments; after writing DEPTH-1 go to IDLE. req_in ignored (no write, no rvalid). clear_in ignored.
- IDLE: ready_out = 1, busy_out = 0.
  - Accepted write: for each i with be_in[i]=1, mem[addr_in] byte i <= wdata_in byte i; other bytes unchanged. be_in = 0 is a legal no-op. No rvalid.
  - Accepted read: mem[addr_in] captured; rvalid_out and rdata_out per Timing.
  - clear_in = 1: next state CLEAR, counter <= 0. An access presented in the same cycle is still accepted and completes (read returns pre-clear contents).
- Reset mid-CLEAR restarts the clear from address 0. Reset with a read in flight drops the rvalid_out strobe.
- Addresses are always in range (full decode); no wrap logic beyond counter reaching DEPTH-1.

## Timing
- ready_out/busy_out are registered state decodes, complementary at all times.
- Clear duration: exactly DEPTH cycles in CLEAR; ready_out rises on the edge after the write to DEPTH-1. After rst_in deasserts at edge N, first acceptance possible at edge N+DEPTH.
- Read latency (SPRAM_OUTREG_EN undefined): read accepted at edge N -> rvalid_out = 1, rdata_out valid during cycle after N (until edge N+1).
- Write latency: word visible to a read accepted at the next edge (back-to-back write then read of same address returns new data).
- Throughput: one access per cycle in IDLE, reads fully pipelined.

## Configuration
- SPRAM_OUTREG_EN defined: one additional register stage on rdata_out and rvalid_out; read latency 2 cycles (accept at edge N -> valid after edge N+1). Extra stage is reset with rst_in, and drains normally across entry into CLEAR.
- Undefined: latency 1 as above. Handshake, clear and write behaviour identical in both builds.

## Test plan
- Reset release: rst_in high 2 cycles then low -> busy_out=1/ready_out=0 for exactly 8 cycles (defaults), then ready_out=1; reads of all 8 addresses return 16'h0000.
- Byte-enabled write: write 16'hA5C3 to addr 5 with be=2'b11, then 16'h1234 with be=2'b01 -> read addr 5 returns 16'hA534, rvalid_out single-cycle at latency 1 (2 with SPRAM_OUTREG_EN).
- Back-to-back: write addr 2 = 16'hBEEF, next cycle read addr 2, next read addr 7 -> consecutive rvalid cycles returning 16'hBEEF then addr-7 contents.
- Clear mid-operation: fill all addresses with 16'hFFFF, pulse clear_in with a read of addr 3 in same cycle -> that read returns 16'hFFFF; ready_out low 8 cycles; reads then return 16'h0000; req_in held high during clear causes no rvalid and no writes.
- Reset mid-clear: assert rst_in on 4th CLEAR cycle -> clear restarts at 0, full 8 busy cycles after release, all locations 0.
- Parameter sweep: DATA_WIDTH=32, ADDR_WIDTH=6 -> 64-cycle clear; be_in=4'b1010 writes only bytes 1 and 3.
